// File: rtl/snn_spike_pattern_buffer.sv
// rtl/snn_spike_pattern_buffer.sv - double-buffered spike pattern store with timestep replay; optional macro SPIKE_BUF_REPEAT_EN
module snn_spike_pattern_buffer #(
  parameter int NUM_INPUTS         = 784,
  parameter int SPIKES_PER_BATCH   = 32,
  parameter int MAX_TIMESTEPS_BITS = 7,
  parameter int NUM_BATCHES        = (NUM_INPUTS + SPIKES_PER_BATCH - 1) / SPIKES_PER_BATCH,
  parameter int BATCH_ADDR_WIDTH   = $clog2(NUM_BATCHES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [BATCH_ADDR_WIDTH-1:0]   wr_batch,
  input  logic [MAX_TIMESTEPS_BITS-1:0] wr_timestep,
  input  logic [SPIKES_PER_BATCH-1:0]   wr_data,
  input  logic                          rd_en,
  input  logic [BATCH_ADDR_WIDTH-1:0]   rd_batch,
  input  logic [MAX_TIMESTEPS_BITS-1:0] rd_timestep,
  output logic [SPIKES_PER_BATCH-1:0]   rd_data,
  input  logic                          swap_req,
  output logic                          active_bank,
  input  logic                          start,
`ifdef SPIKE_BUF_REPEAT_EN
  input  logic [7:0]                    repeat_cnt,
`endif
  input  logic [MAX_TIMESTEPS_BITS:0]   sim_time,
  output logic [NUM_INPUTS-1:0]         spikes,
  output logic                          spikes_valid,
  input  logic                          spikes_ready,
  output logic [MAX_TIMESTEPS_BITS-1:0] timestep_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int TW         = MAX_TIMESTEPS_BITS;
  localparam int DEPTH      = 1 << TW;
  localparam int BANK_WORDS = DEPTH * NUM_BATCHES;
  localparam int ADDR_W     = $clog2(BANK_WORDS);
  localparam int FCNT_W     = BATCH_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SPIKES_PER_BATCH-1:0] bank0 [BANK_WORDS];
  logic [SPIKES_PER_BATCH-1:0] bank1 [BANK_WORDS];

  logic [SPIKES_PER_BATCH-1:0] act_q;
  logic [FCNT_W-1:0]           fetch_cnt;
  logic [TW:0]                 eff_time;
  logic [TW:0]                 eff_in;
  logic                        swap_pending;
  logic                        last_step;
  logic                        more_passes;
  logic                        wr_ok;
  logic                        rd_ok;
  logic                        fetch_rd;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W-1:0]           rd_addr;
  logic [ADDR_W-1:0]           fetch_addr;

  // Words of one timestep are packed contiguously inside a bank
  function automatic logic [ADDR_W-1:0] word_addr(input logic [TW-1:0] ts,
                                                  input logic [BATCH_ADDR_WIDTH-1:0] b);
    word_addr = ADDR_W'(ts) * ADDR_W'(NUM_BATCHES) + ADDR_W'(b);
  endfunction

  assign wr_ok      = int'(wr_batch) < NUM_BATCHES;
  assign rd_ok      = int'(rd_batch) < NUM_BATCHES;
  assign wr_addr    = word_addr(wr_timestep, wr_batch);
  assign rd_addr    = word_addr(rd_timestep, rd_batch);
  assign fetch_addr = word_addr(timestep_idx, fetch_cnt[BATCH_ADDR_WIDTH-1:0]);
  assign fetch_rd   = (state_q == S_FETCH) && (int'(fetch_cnt) < NUM_BATCHES);

  // Requested length clamped to the bank depth
  assign eff_in    = (sim_time > {1'b1, {TW{1'b0}}}) ? {1'b1, {TW{1'b0}}} : sim_time;
  assign last_step = (({1'b0, timestep_idx} + 1'b1) == eff_time);

`ifdef SPIKE_BUF_REPEAT_EN
  logic [7:0] pass_left;

  // Extra passes still owed; loaded on start, spent at each wrap back to timestep 0
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_left <= '0;
    end else if (state_q == S_IDLE && start) begin
      pass_left <= repeat_cnt;
    end else if (state_q == S_PRESENT && spikes_ready && last_step && pass_left != 8'd0) begin
      pass_left <= pass_left - 8'd1;
    end
  end

  assign more_passes = (pass_left != 8'd0);
`else
  assign more_passes = 1'b0;
`endif

  // Host writes land in the load bank; batch indices past the last batch are dropped
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      if (active_bank) begin
        bank0[wr_addr] <= wr_data;
      end else begin
        bank1[wr_addr] <= wr_data;
      end
    end
  end

  // Host read-back from the load bank, registered; same-cycle write returns old word
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (!rd_ok) begin
        rd_data <= '0;
      end else if (active_bank) begin
        rd_data <= bank0[rd_addr];
      end else begin
        rd_data <= bank1[rd_addr];
      end
    end
  end

  // Replay port: one active-bank word per FETCH cycle, consumed the cycle after
  always_ff @(posedge clk) begin
    if (fetch_rd) begin
      act_q <= active_bank ? bank1[fetch_addr] : bank0[fetch_addr];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    spikes_valid = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (eff_in == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (fetch_cnt == FCNT_W'(NUM_BATCHES)) begin
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy         = 1'b1;
        spikes_valid = 1'b1;
        if (spikes_ready) begin
          state_d = (last_step && !more_passes) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Replay datapath: length latch, fetch counter, timestep index and spike vector assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      eff_time     <= '0;
      fetch_cnt    <= '0;
      timestep_idx <= '0;
      spikes       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            eff_time     <= eff_in;
            timestep_idx <= '0;
            fetch_cnt    <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_cnt == FCNT_W'(NUM_BATCHES)) begin
            fetch_cnt <= '0;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
          // Word read at count k lands at count k+1; bits beyond NUM_INPUTS are never stored
          for (int j = 0; j < NUM_INPUTS; j++) begin
            if (fetch_cnt == FCNT_W'(j / SPIKES_PER_BATCH + 1)) begin
              spikes[j] <= act_q[j % SPIKES_PER_BATCH];
            end
          end
        end
        S_PRESENT: begin
          if (spikes_ready) begin
            fetch_cnt <= '0;
            if (!last_step) begin
              timestep_idx <= timestep_idx + 1'b1;
            end else if (more_passes) begin
              timestep_idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bank ownership: immediate swap when idle, otherwise deferred to the IDLE entry after done
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (swap_req) begin
            active_bank <= ~active_bank;
          end
        end
        S_DONE: begin
          if (swap_pending || swap_req) begin
            active_bank <= ~active_bank;
          end
          swap_pending <= 1'b0;
        end
        default: begin
          if (swap_req) begin
            swap_pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_pattern_buffer.sv
// tb/tb_snn_spike_pattern_buffer.sv - scoreboard bench for snn_spike_pattern_buffer
module tb_snn_spike_pattern_buffer;

  localparam int NI  = 784;
  localparam int SPB = 32;
  localparam int TB  = 7;
  localparam int NB  = 25;
  localparam int BW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [BW-1:0] wr_batch;
  logic [TB-1:0] wr_timestep;
  logic [SPB-1:0] wr_data;
  logic          rd_en;
  logic [BW-1:0] rd_batch;
  logic [TB-1:0] rd_timestep;
  logic [SPB-1:0] rd_data;
  logic          swap_req;
  logic          active_bank;
  logic          start;
  logic [TB:0]   sim_time;
  logic [NI-1:0] spikes;
  logic          spikes_valid;
  logic          spikes_ready;
  logic [TB-1:0] timestep_idx;
  logic          busy;
  logic          done;
`ifdef SPIKE_BUF_REPEAT_EN
  logic [7:0]    repeat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TB-1:0] ts;
    logic [NI-1:0] spk;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  snn_spike_pattern_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_batch     (wr_batch),
    .wr_timestep  (wr_timestep),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_batch     (rd_batch),
    .rd_timestep  (rd_timestep),
    .rd_data      (rd_data),
    .swap_req     (swap_req),
    .active_bank  (active_bank),
    .start        (start),
`ifdef SPIKE_BUF_REPEAT_EN
    .repeat_cnt   (repeat_cnt),
`endif
    .sim_time     (sim_time),
    .spikes       (spikes),
    .spikes_valid (spikes_valid),
    .spikes_ready (spikes_ready),
    .timestep_idx (timestep_idx),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NI-1:0] obs, input logic [NI-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NI-1:0] exp_vec(input int t, input logic [15:0] tag);
    logic [NB*SPB-1:0] w;
    for (int b = 0; b < NB; b++) w[b*SPB +: SPB] = {8'(t), 8'(b), tag};
    return w[NI-1:0];
  endfunction

  task automatic write_word(input int t, input int b, input logic [SPB-1:0] d);
    wr_en = 1'b1; wr_timestep = TB'(t); wr_batch = BW'(b); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(input int t, input int b, output logic [SPB-1:0] d);
    rd_en = 1'b1; rd_timestep = TB'(t); rd_batch = BW'(b);
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic load_bank(input logic [15:0] tag);
    for (int t = 0; t < (1 << TB); t++)
      for (int b = 0; b < NB; b++) begin
        wr_en = 1'b1; wr_timestep = TB'(t); wr_batch = BW'(b);
        wr_data = {8'(t), 8'(b), tag};
        tick();
      end
    wr_en = 1'b0;
  endtask

  task automatic push_pass(input int n, input logic [15:0] tag);
    beat_t e;
    for (int t = 0; t < n; t++) begin
      e.ts  = TB'(t);
      e.spk = exp_vec(t, tag);
      sb.push_back(e);
    end
  endtask

  task automatic run_replay(input int budget, input int stall_ts, input int swap_ts,
                            input int start_ts, input int rst_ts,
                            output int beats, output int dones);
    beat_t e;
    bit stalled, swapped, restarted;
    beats = 0; dones = 0; stalled = 0; swapped = 0; restarted = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        dones++;
        check("busy_low_at_done", NI'(busy), NI'(0));
        check("valid_low_at_done", NI'(spikes_valid), NI'(0));
        break;
      end
      if (spikes_valid) begin
        check("busy_high_in_replay", NI'(busy), NI'(1));
        if (int'(timestep_idx) == rst_ts) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check("rst_busy", NI'(busy), NI'(0));
          check("rst_valid", NI'(spikes_valid), NI'(0));
          check("rst_done", NI'(done), NI'(0));
          check("rst_bank", NI'(active_bank), NI'(0));
          check("rst_idx", NI'(timestep_idx), NI'(0));
          check("rst_spikes", spikes, NI'(0));
          for (int k = 0; k < 40; k++) begin
            tick();
            if (done) dones++;
          end
          return;
        end
        if (int'(timestep_idx) == stall_ts && !stalled) begin
          stalled = 1;
          spikes_ready = 1'b0;
          for (int k = 0; k < 20; k++) begin
            tick();
            check("stall_valid", NI'(spikes_valid), NI'(1));
            check("stall_idx", NI'(timestep_idx), NI'(stall_ts));
            if (sb.size() > 0) check("stall_spikes", spikes, sb[0].spk);
          end
          spikes_ready = 1'b1;
        end
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow: observed beat idx %0d expected no beat", timestep_idx);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("beat_idx", NI'(timestep_idx), NI'(e.ts));
          check("beat_spikes", spikes, e.spk);
        end
        beats++;
        if (int'(timestep_idx) == swap_ts && !swapped) begin swapped = 1; swap_req = 1'b1; end
        if (int'(timestep_idx) == start_ts && !restarted) begin restarted = 1; start = 1'b1; end
      end
      tick();
      swap_req = 1'b0;
      start    = 1'b0;
    end
  endtask

  initial begin
    logic [SPB-1:0] d;
    int beats, dones;

    rst = 1'b1; wr_en = 1'b0; wr_batch = '0; wr_timestep = '0; wr_data = '0;
    rd_en = 1'b0; rd_batch = '0; rd_timestep = '0; swap_req = 1'b0; start = 1'b0;
    sim_time = '0; spikes_ready = 1'b1;
`ifdef SPIKE_BUF_REPEAT_EN
    repeat_cnt = 8'd0;
`endif
    repeat (3) tick();
    check("reset_busy", NI'(busy), NI'(0));
    check("reset_valid", NI'(spikes_valid), NI'(0));
    check("reset_done", NI'(done), NI'(0));
    check("reset_idx", NI'(timestep_idx), NI'(0));
    check("reset_bank", NI'(active_bank), NI'(0));
    check("reset_rd_data", NI'(rd_data), NI'(0));
    check("reset_spikes", spikes, NI'(0));
    rst = 1'b0;
    tick();

    // Host access to load bank (bank1 while active_bank=0)
    write_word(0, 0, 32'h0);
    read_word(0, 0, d);
    check("rd_t0_b0", NI'(d), NI'(0));
    write_word(6, 0, 32'h11111111);
    write_word(5, 25, 32'hBAD0BAD0);
    read_word(6, 0, d);
    check("oob_write_ignored", NI'(d), NI'(32'h11111111));
    write_word(5, 3, 32'hDEADBEEF);
    read_word(5, 3, d);
    check("rd_deadbeef", NI'(d), NI'(32'hDEADBEEF));
    check("bank_still_0", NI'(active_bank), NI'(0));
    wr_en = 1'b1; wr_timestep = 7'd5; wr_batch = 5'd3; wr_data = 32'hCAFEF00D;
    rd_en = 1'b1; rd_timestep = 7'd5; rd_batch = 5'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("raw_old_data", NI'(rd_data), NI'(32'hDEADBEEF));
    read_word(5, 3, d);
    check("raw_new_data", NI'(d), NI'(32'hCAFEF00D));

    // Idle swap takes effect next cycle; host then sees the other bank
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("idle_swap_to_1", NI'(active_bank), NI'(1));
    write_word(5, 3, 32'h01234567);
    read_word(5, 3, d);
    check("bank0_word", NI'(d), NI'(32'h01234567));
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("idle_swap_to_0", NI'(active_bank), NI'(0));
    read_word(5, 3, d);
    check("bank1_word_kept", NI'(d), NI'(32'hCAFEF00D));

    // Fill bank1 with pattern and make it active
    load_bank(16'hA5A5);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("swap_to_bank1", NI'(active_bank), NI'(1));

    // 100 timesteps, stall at 7, stray start at 12
    push_pass(100, 16'hA5A5);
    sim_time = 8'd100; start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", NI'(busy), NI'(1));
    run_replay(4000, 7, -1, 12, -1, beats, dones);
    check("a_beats", NI'(beats), NI'(100));
    check("a_dones", NI'(dones), NI'(1));
    check("a_sb_empty", NI'(sb.size()), NI'(0));
    tick();
    check("a_done_one_cycle", NI'(done), NI'(0));
    check("a_idle_busy", NI'(busy), NI'(0));

    // sim_time beyond depth clamps to 128
    push_pass(128, 16'hA5A5);
    sim_time = 8'd200; start = 1'b1; tick(); start = 1'b0;
    run_replay(5000, -1, -1, -1, -1, beats, dones);
    check("b_beats", NI'(beats), NI'(128));
    check("b_dones", NI'(dones), NI'(1));
    tick();

    // sim_time=0: straight to done, no spikes
    sim_time = 8'd0; start = 1'b1; tick(); start = 1'b0;
    check("c_done", NI'(done), NI'(1));
    check("c_valid", NI'(spikes_valid), NI'(0));
    check("c_busy", NI'(busy), NI'(0));
    tick();
    check("c_done_gone", NI'(done), NI'(0));
    check("c_valid_after", NI'(spikes_valid), NI'(0));

    // Load bank0, then swap mid-replay deferred to IDLE entry
    load_bank(16'h5A5A);
    push_pass(20, 16'hA5A5);
    sim_time = 8'd20; start = 1'b1; tick(); start = 1'b0;
    run_replay(1500, -1, 10, -1, -1, beats, dones);
    check("d_beats", NI'(beats), NI'(20));
    check("d_dones", NI'(dones), NI'(1));
    check("d_bank_held_at_done", NI'(active_bank), NI'(1));
    tick();
    check("d_bank_toggled", NI'(active_bank), NI'(0));

    // Swap and start together: replay uses new bank1; reset at timestep 50
    push_pass(100, 16'hA5A5);
    sim_time = 8'd100; swap_req = 1'b1; start = 1'b1; tick(); swap_req = 1'b0; start = 1'b0;
    check("e_bank_swapped_first", NI'(active_bank), NI'(1));
    run_replay(3000, -1, -1, -1, 50, beats, dones);
    check("e_beats_before_rst", NI'(beats), NI'(50));
    check("e_no_done", NI'(dones), NI'(0));
    sb.delete();

`ifdef SPIKE_BUF_REPEAT_EN
    // Three passes over 4 timesteps from bank0
    repeat_cnt = 8'd2;
    push_pass(4, 16'h5A5A); push_pass(4, 16'h5A5A); push_pass(4, 16'h5A5A);
    sim_time = 8'd4; start = 1'b1; tick(); start = 1'b0;
    repeat_cnt = 8'd0;
    run_replay(1000, -1, -1, -1, -1, beats, dones);
    check("f_beats", NI'(beats), NI'(12));
    check("f_dones", NI'(dones), NI'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
